// File: rtl/conv_loop_scheduler.sv
// Convolution loop-nest scheduler: walks out_y/out_x/out_ch/in_ch/k_y/k_x and
// issues one MAC step descriptor per accepted handshake, with padding and accumulate flags.
module conv_loop_scheduler #(
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int INPUT_NB_CHANNELS  = 4,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int KERNEL_SIZE        = 3,
   localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
   localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
   localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
   localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
   localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1
) (
   input  logic           clk,
   input  logic           arst_in,
   input  logic           start,
   output logic           running,
   output logic           done,
   output logic           step_valid,
   input  logic           step_ready,
   output logic [XW-1:0]  out_x,
   output logic [YW-1:0]  out_y,
   output logic [COW-1:0] out_ch,
   output logic [CIW-1:0] in_ch,
   output logic [KW-1:0]  k_x,
   output logic [KW-1:0]  k_y,
   output logic [XW-1:0]  in_x,
   output logic [YW-1:0]  in_y,
   output logic           pad,
   output logic           acc_first,
   output logic           acc_last
);

   // Sign bit plus one carry bit above the wider operand keeps the tap offset exact.
   localparam int SXW = ((XW > KW) ? XW : KW) + 2;
   localparam int SYW = ((YW > KW) ? YW : KW) + 2;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t         state_r, state_nx_s;
   logic [XW-1:0]  ox_r, ox_nx_s;
   logic [YW-1:0]  oy_r, oy_nx_s;
   logic [COW-1:0] oc_r, oc_nx_s;
   logic [CIW-1:0] ic_r, ic_nx_s;
   logic [KW-1:0]  kx_r, kx_nx_s;
   logic [KW-1:0]  ky_r, ky_nx_s;

   logic kx_max_s, ky_max_s, ic_max_s, oc_max_s, ox_max_s, oy_max_s;
   logic c_ky_s, c_ic_s, c_oc_s, c_ox_s, c_oy_s, all_max_s;
   logic run_s, pad_s;
   logic [SXW-1:0] ix_s;
   logic [SYW-1:0] iy_s;

   assign kx_max_s = (kx_r == KW'(KERNEL_SIZE - 1));
   assign ky_max_s = (ky_r == KW'(KERNEL_SIZE - 1));
   assign ic_max_s = (ic_r == CIW'(INPUT_NB_CHANNELS - 1));
   assign oc_max_s = (oc_r == COW'(OUTPUT_NB_CHANNELS - 1));
   assign ox_max_s = (ox_r == XW'(FEATURE_MAP_WIDTH - 1));
   assign oy_max_s = (oy_r == YW'(FEATURE_MAP_HEIGHT - 1));

   // Carry into each loop level: every inner level is at its bound.
   assign c_ky_s    = kx_max_s;
   assign c_ic_s    = c_ky_s & ky_max_s;
   assign c_oc_s    = c_ic_s & ic_max_s;
   assign c_ox_s    = c_oc_s & oc_max_s;
   assign c_oy_s    = c_ox_s & ox_max_s;
   assign all_max_s = c_oy_s & oy_max_s;

   // State and loop counter registers.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state_r <= IDLE;
         ox_r    <= XW'(0);
         oy_r    <= YW'(0);
         oc_r    <= COW'(0);
         ic_r    <= CIW'(0);
         kx_r    <= KW'(0);
         ky_r    <= KW'(0);
      end else begin
         state_r <= state_nx_s;
         ox_r    <= ox_nx_s;
         oy_r    <= oy_nx_s;
         oc_r    <= oc_nx_s;
         ic_r    <= ic_nx_s;
         kx_r    <= kx_nx_s;
         ky_r    <= ky_nx_s;
      end
   end

   // Next-state and counter advance; counters only move on an accepted step.
   always_comb begin
      state_nx_s = state_r;
      ox_nx_s    = ox_r;
      oy_nx_s    = oy_r;
      oc_nx_s    = oc_r;
      ic_nx_s    = ic_r;
      kx_nx_s    = kx_r;
      ky_nx_s    = ky_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
               ox_nx_s    = XW'(0);
               oy_nx_s    = YW'(0);
               oc_nx_s    = COW'(0);
               ic_nx_s    = CIW'(0);
               kx_nx_s    = KW'(0);
               ky_nx_s    = KW'(0);
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (step_ready) begin
               kx_nx_s = kx_max_s ? KW'(0) : kx_r + KW'(1);
               ky_nx_s = !c_ky_s ? ky_r : (ky_max_s ? KW'(0)  : ky_r + KW'(1));
               ic_nx_s = !c_ic_s ? ic_r : (ic_max_s ? CIW'(0) : ic_r + CIW'(1));
               oc_nx_s = !c_oc_s ? oc_r : (oc_max_s ? COW'(0) : oc_r + COW'(1));
               ox_nx_s = !c_ox_s ? ox_r : (ox_max_s ? XW'(0)  : ox_r + XW'(1));
               oy_nx_s = !c_oy_s ? oy_r : (oy_max_s ? YW'(0)  : oy_r + YW'(1));
               state_nx_s = all_max_s ? DONE : RUN;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Input tap position; a set sign bit also trips the unsigned upper-bound test.
   assign ix_s  = SXW'(ox_r) + SXW'(kx_r) - SXW'(KERNEL_SIZE / 2);
   assign iy_s  = SYW'(oy_r) + SYW'(ky_r) - SYW'(KERNEL_SIZE / 2);
   assign pad_s = ix_s[SXW-1] | (ix_s >= SXW'(FEATURE_MAP_WIDTH)) |
                  iy_s[SYW-1] | (iy_s >= SYW'(FEATURE_MAP_HEIGHT));

   assign run_s      = (state_r == RUN);
   assign running    = (state_r != IDLE);
   assign done       = (state_r == DONE);
   assign step_valid = run_s;
   assign out_x      = ox_r;
   assign out_y      = oy_r;
   assign out_ch     = oc_r;
   assign in_ch      = ic_r;
   assign k_x        = kx_r;
   assign k_y        = ky_r;
   assign in_x       = pad_s ? XW'(0) : ix_s[XW-1:0];
   assign in_y       = pad_s ? YW'(0) : iy_s[YW-1:0];
   assign pad        = run_s & pad_s;
   assign acc_first  = run_s & (ic_r == CIW'(0)) & (ky_r == KW'(0)) & (kx_r == KW'(0));
   assign acc_last   = run_s & ic_max_s & ky_max_s & kx_max_s;

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Directed bench for conv_loop_scheduler: a small 2x2/K3 instance for timing, padding,
// start filtering and mid-pass reset; a 4x4x2x2 instance under random backpressure.
module tb_conv_loop_scheduler;

   logic clk, rst;
   int   checks, errors;

   logic       a_start, a_ready, a_running, a_done, a_valid;
   logic [0:0] a_ox, a_oy, a_oc, a_ic, a_ix, a_iy;
   logic [1:0] a_kx, a_ky;
   logic       a_pad, a_first, a_last;

   logic       b_start, b_ready, b_running, b_done, b_valid;
   logic [1:0] b_ox, b_oy, b_ix, b_iy, b_kx, b_ky;
   logic [0:0] b_oc, b_ic;
   logic       b_pad, b_first, b_last;

   conv_loop_scheduler #(
      .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
      .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3)
   ) dut_a (
      .clk(clk), .arst_in(rst), .start(a_start), .running(a_running), .done(a_done),
      .step_valid(a_valid), .step_ready(a_ready), .out_x(a_ox), .out_y(a_oy),
      .out_ch(a_oc), .in_ch(a_ic), .k_x(a_kx), .k_y(a_ky), .in_x(a_ix), .in_y(a_iy),
      .pad(a_pad), .acc_first(a_first), .acc_last(a_last)
   );

   conv_loop_scheduler #(
      .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
      .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3)
   ) dut_b (
      .clk(clk), .arst_in(rst), .start(b_start), .running(b_running), .done(b_done),
      .step_valid(b_valid), .step_ready(b_ready), .out_x(b_ox), .out_y(b_oy),
      .out_ch(b_oc), .in_ch(b_ic), .k_x(b_kx), .k_y(b_ky), .in_x(b_ix), .in_y(b_iy),
      .pad(b_pad), .acc_first(b_first), .acc_last(b_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected descriptor of step idx for the 2x2, Cin=Cout=1, K=3 instance.
   task automatic check_a(input int idx);
      int kx, ky, ox, oy, ix, iy;
      logic p;
      kx = idx % 3;  ky = (idx / 3) % 3;  ox = (idx / 9) % 2;  oy = idx / 18;
      ix = ox + kx - 1;  iy = oy + ky - 1;
      p  = (ix < 0) || (ix > 1) || (iy < 0) || (iy > 1);
      chk("A.step_valid", a_valid, 1);
      chk("A.out_x", a_ox, ox);
      chk("A.out_y", a_oy, oy);
      chk("A.out_ch", a_oc, 0);
      chk("A.in_ch", a_ic, 0);
      chk("A.k_x", a_kx, kx);
      chk("A.k_y", a_ky, ky);
      chk("A.in_x", a_ix, p ? 0 : ix);
      chk("A.in_y", a_iy, p ? 0 : iy);
      chk("A.pad", a_pad, p);
      chk("A.acc_first", a_first, (kx == 0) && (ky == 0));
      chk("A.acc_last", a_last, (kx == 2) && (ky == 2));
      chk("A.done_in_run", a_done, 0);
   endtask

   // Expected descriptor of step idx for the 4x4, Cin=Cout=2, K=3 instance.
   task automatic check_b(input int idx);
      int kx, ky, ic, oc, ox, oy, ix, iy;
      logic p;
      kx = idx % 3;  ky = (idx / 3) % 3;  ic = (idx / 9) % 2;
      oc = (idx / 18) % 2;  ox = (idx / 36) % 4;  oy = idx / 144;
      ix = ox + kx - 1;  iy = oy + ky - 1;
      p  = (ix < 0) || (ix > 3) || (iy < 0) || (iy > 3);
      chk("B.step_valid", b_valid, 1);
      chk("B.out_x", b_ox, ox);
      chk("B.out_y", b_oy, oy);
      chk("B.out_ch", b_oc, oc);
      chk("B.in_ch", b_ic, ic);
      chk("B.k_x", b_kx, kx);
      chk("B.k_y", b_ky, ky);
      chk("B.in_x", b_ix, p ? 0 : ix);
      chk("B.in_y", b_iy, p ? 0 : iy);
      chk("B.pad", b_pad, p);
      chk("B.acc_first", b_first, (ic == 0) && (ky == 0) && (kx == 0));
      chk("B.acc_last", b_last, (ic == 1) && (ky == 2) && (kx == 2));
   endtask

   task automatic full_pass_a();
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int s = 0; s < 36; s++) begin
         check_a(s);
         tick();
      end
      chk("A.done_pulse", a_done, 1);
      chk("A.running_in_done", a_running, 1);
      chk("A.valid_in_done", a_valid, 0);
      tick();
      chk("A.done_cleared", a_done, 0);
      chk("A.idle_after_done", a_running, 0);
   endtask

   initial begin
      int acc, cyc;
      checks = 0;  errors = 0;
      rst = 1'b1;
      a_start = 1'b0;  a_ready = 1'b1;
      b_start = 1'b0;  b_ready = 1'b0;
      repeat (2) tick();

      chk("A.reset_running", a_running, 0);
      chk("A.reset_done", a_done, 0);
      chk("A.reset_valid", a_valid, 0);
      chk("B.reset_running", b_running, 0);
      chk("B.reset_valid", b_valid, 0);

      rst = 1'b0;
      repeat (3) tick();
      chk("A.idle_wait_valid", a_valid, 0);
      chk("A.idle_wait_running", a_running, 0);

      // Pass 1: latency, 36 back-to-back steps, hand-computed taps at steps 0/4/8.
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int s = 0; s < 36; s++) begin
         check_a(s);
         chk("A.running", a_running, 1);
         if (s == 0) begin
            chk("A.s0_pad", a_pad, 1);
            chk("A.s0_kx", a_kx, 0);
            chk("A.s0_ox", a_ox, 0);
         end
         if (s == 4) begin
            chk("A.s4_kx", a_kx, 1);
            chk("A.s4_ky", a_ky, 1);
            chk("A.s4_ix", a_ix, 0);
            chk("A.s4_iy", a_iy, 0);
            chk("A.s4_pad", a_pad, 0);
         end
         if (s == 8) begin
            chk("A.s8_ix", a_ix, 1);
            chk("A.s8_iy", a_iy, 1);
            chk("A.s8_pad", a_pad, 0);
         end
         tick();
      end
      chk("A.done_pulse", a_done, 1);
      chk("A.valid_in_done", a_valid, 0);
      tick();
      chk("A.done_cleared", a_done, 0);
      chk("A.idle_after_done", a_running, 0);

      // Pass 2: start toggled throughout RUN and held in the DONE cycle.
      a_start = 1'b1;
      tick();
      for (int s = 0; s < 36; s++) begin
         a_start = (s % 2 == 1);
         check_a(s);
         tick();
      end
      chk("A.spam_done_pulse", a_done, 1);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("A.spam_no_restart_valid", a_valid, 0);
      chk("A.spam_no_restart_running", a_running, 0);
      chk("A.spam_done_single", a_done, 0);
      tick();
      chk("A.spam_idle_valid", a_valid, 0);

      // Pass 3: asynchronous reset after 10 steps abandons the pass.
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int s = 0; s < 10; s++) begin
         check_a(s);
         tick();
      end
      rst = 1'b1;
      #1;
      chk("A.arst_running", a_running, 0);
      chk("A.arst_valid", a_valid, 0);
      chk("A.arst_done", a_done, 0);
      chk("A.arst_kx", a_kx, 0);
      chk("A.arst_ky", a_ky, 0);
      chk("A.arst_ox", a_ox, 0);
      tick();
      rst = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk("A.post_arst_done", a_done, 0);
         chk("A.post_arst_running", a_running, 0);
         tick();
      end
      full_pass_a();

      // Instance B under ~50% random backpressure.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      acc = 0;  cyc = 0;
      while (acc < 576 && cyc < 4000) begin
         b_ready = ($urandom_range(0, 1) == 1);
         check_b(acc);
         tick();
         cyc++;
         if (b_ready) acc++;
      end
      b_ready = 1'b0;
      chk("B.accepted_steps", acc, 576);
      chk("B.done_pulse", b_done, 1);
      chk("B.valid_in_done", b_valid, 0);
      tick();
      chk("B.done_cleared", b_done, 0);
      chk("B.idle_after_done", b_running, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
